// File: rtl/core_inst_sequencer.sv
// Autonomous instruction sequencer for one attention core: Q/K write, K load,
// execute, ofifo->pmem move, accumulation and div with handshake spacing.
// Ports: clk/reset (async, active-high); start begins one sequence from IDLE;
//   in_data/in_valid/in_ready take Q then K vectors from the host;
//   mem_in/inst drive the core (registered, one cycle behind the state that
//   produced them); busy/done/phase report progress.
module core_inst_sequencer #(
   parameter int bw              = 8,
   parameter int pr              = 16,
   parameter int col             = 8,
   parameter int total_cycle     = 8,
   parameter int gap_cycle       = 10,
   parameter int drain_cycle     = 6,
   parameter int handshake_cycle = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [pr*bw-1:0]  in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [pr*bw-1:0]  mem_in,
   output logic [18:0]       inst,
   output logic              busy,
   output logic              done,
   output logic [3:0]        phase
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_QWR   = 4'd1;
   localparam logic [3:0] S_KWR   = 4'd2;
   localparam logic [3:0] S_LOAD  = 4'd3;
   localparam logic [3:0] S_GAP1  = 4'd4;
   localparam logic [3:0] S_EXEC  = 4'd5;
   localparam logic [3:0] S_GAP2  = 4'd6;
   localparam logic [3:0] S_OFIFO = 4'd7;
   localparam logic [3:0] S_ACC   = 4'd8;
   localparam logic [3:0] S_DRAIN = 4'd9;
   localparam logic [3:0] S_DIV   = 4'd10;
   localparam logic [3:0] S_DONE  = 4'd11;

   // Last value of the in-state counter for each timed state.
   localparam logic [15:0] T_LAST    = 16'(total_cycle - 1);
   localparam logic [15:0] C_LAST    = 16'(col - 1);
   localparam logic [15:0] LOAD_LAST = 16'(col + 1);
   localparam logic [15:0] K_LAST    = 16'(col);
   localparam logic [15:0] G_LAST    = 16'(gap_cycle - 1);
   localparam logic [15:0] D_LAST    = 16'(drain_cycle - 1);
   localparam logic [15:0] H_LAST    = 16'(handshake_cycle);
   localparam logic [3:0]  ROW_LAST  = 4'(total_cycle - 1);

   logic [3:0]  state, state_nx;
   logic [15:0] cnt, cnt_nx;
   logic [15:0] cnt_m1;
   logic [3:0]  row, row_nx;
   logic [18:0] inst_nx;
   logic        accept;

   assign in_ready = (state == S_QWR) || (state == S_KWR);
   assign accept   = in_ready && in_valid;
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign phase    = state;
   assign cnt_m1   = cnt - 16'd1;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      row_nx   = row;
      inst_nx  = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_QWR;
               cnt_nx   = '0;
               row_nx   = '0;
            end
         end
         // Write phases count accepted vectors only; a cycle without
         // in_valid issues an all-zero bubble and holds the address.
         S_QWR: begin
            if (accept) begin
               inst_nx[4]     = 1'b1;
               inst_nx[15:12] = cnt[3:0];
               if (cnt == T_LAST) begin
                  state_nx = S_KWR;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 16'd1;
               end
            end
         end
         S_KWR: begin
            if (accept) begin
               inst_nx[2]     = 1'b1;
               inst_nx[15:12] = cnt[3:0];
               if (cnt == C_LAST) begin
                  state_nx = S_LOAD;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 16'd1;
               end
            end
         end
         // load is framed by one idle-address cycle on each side of the
         // col kmem reads.
         S_LOAD: begin
            inst_nx[6] = 1'b1;
            if ((cnt >= 16'd1) && (cnt <= K_LAST)) begin
               inst_nx[3]     = 1'b1;
               inst_nx[15:12] = cnt_m1[3:0];
            end
            if (cnt == LOAD_LAST) begin
               state_nx = S_GAP1;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_GAP1, S_GAP2: begin
            if (cnt == G_LAST) begin
               state_nx = (state == S_GAP1) ? S_EXEC : S_OFIFO;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_EXEC: begin
            inst_nx[7]     = 1'b1;
            inst_nx[5]     = 1'b1;
            inst_nx[15:12] = cnt[3:0];
            if (cnt == T_LAST) begin
               state_nx = S_GAP2;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_OFIFO: begin
            inst_nx[16]   = 1'b1;
            inst_nx[0]    = 1'b1;
            inst_nx[11:8] = cnt[3:0];
            if (cnt == T_LAST) begin
               state_nx = S_ACC;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_ACC: begin
            inst_nx[17]   = 1'b1;
            inst_nx[1]    = 1'b1;
            inst_nx[11:8] = cnt[3:0];
            if (cnt == T_LAST) begin
               state_nx = S_DRAIN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_DRAIN: begin
            if (cnt == D_LAST) begin
               state_nx = S_DIV;
               cnt_nx   = '0;
               row_nx   = '0;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         // Each row holds div/pmem_rd for the issue cycle plus the
         // handshake spacing, so cnt runs 0..handshake_cycle per row.
         S_DIV: begin
            inst_nx[18]   = 1'b1;
            inst_nx[1]    = 1'b1;
            inst_nx[11:8] = row;
            if (cnt == H_LAST) begin
               cnt_nx = '0;
               if (row == ROW_LAST) begin
                  state_nx = S_DONE;
               end else begin
                  row_nx = row + 4'd1;
               end
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            row_nx   = '0;
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            row_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         row    <= '0;
         inst   <= '0;
         mem_in <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         row   <= row_nx;
         inst  <= inst_nx;
         if (accept) begin
            mem_in <= in_data;
         end
      end
   end

endmodule

// File: doc/core_inst_sequencer.md
Name: core_inst_sequencer

Overview:
Autonomous instruction sequencer for one attention core. On start it produces, cycle by cycle, the 19-bit inst word and the mem_in bus that the host bench currently drives by hand: Q write, K write, K load, execute, ofifo-to-pmem move, accumulation, and div with handshake spacing. One instance sits in front of each core's inst/mem_in inputs in fullchip.

Parameters:
bw, 8, element bit width
pr, 16, elements per Q/K vector
col, 8, K vectors / PE columns (1..16)
total_cycle, 8, Q vectors processed (1..16)
gap_cycle, 10, idle cycles after LOAD and after EXEC
drain_cycle, 6, idle cycles after ACC
handshake_cycle, 10, idle cycles after each div issue

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
start  in  1  begin one full sequence (sampled in IDLE only)
in_data  in  pr*bw  Q or K vector from host
in_valid  in  1  in_data valid
in_ready  out  1  sequencer accepts in_data this cycle
mem_in  out  pr*bw  to core mem_in
inst  out  19  to core inst: [18]div [17]acc [16]ofifo_rd [15:12]qkmem_add [11:8]pmem_add [7]execute [6]load [5]qmem_rd [4]qmem_wr [3]kmem_rd [2]kmem_wr [1]pmem_rd [0]pmem_wr
busy  out  1  high from cycle after start until done
done  out  1  one-cycle pulse at end of sequence
phase  out  4  current state code (debug)

Behaviour:
- Reset (async): state IDLE, all counters 0, inst=0, mem_in=0, in_ready=0, busy=0, done=0, phase=0.
- inst and mem_in are registered: fields for state-cycle n appear at clk edge ending n.
- States/codes: IDLE0 QWR1 KWR2 LOAD3 GAP1 4 EXEC5 GAP2 6 OFIFO7 ACC8 DRAIN9 DIV10 DONE11.
- IDLE: start=1 -> QWR next cycle; start while busy ignored.
- QWR: in_ready=1. Each in_valid cycle: inst.qmem_wr=1, qkmem_add=idx, mem_in=in_data, idx++. in_valid=0: inst=0 (bubble), idx held. After total_cycle accepts -> KWR, idx=0.
- KWR: same with kmem_wr, col accepts -> LOAD. in_ready=0 in all other states; mem_in holds last value.
- LOAD: col+2 cycles, load=1 throughout. Cycle 0: kmem_rd=0, add=0. Cycles 1..col: kmem_rd=1, qkmem_add=cycle-1. Cycle col+1: kmem_rd=0, add=0. -> GAP1.
- GAP1/GAP2: gap_cycle cycles inst=0. GAP1->EXEC, GAP2->OFIFO.
- EXEC: total_cycle cycles, execute=1, qmem_rd=1, qkmem_add=i. -> GAP2.
- OFIFO: total_cycle cycles, ofifo_rd=1, pmem_wr=1, pmem_add=i. -> ACC.
- ACC: total_cycle cycles, pmem_rd=1, acc=1, pmem_add=i. -> DRAIN (drain_cycle cycles, inst=0) -> DIV.
- DIV: per row i in 0..total_cycle-1: 1+handshake_cycle cycles with div=1, pmem_rd=1, pmem_add=i. After last row -> DONE.
- DONE: one cycle, inst=0, done=1, busy=0 next -> IDLE. start in DONE ignored.
- Unused inst fields always 0; address fields 4-bit, no wrap beyond 15 (parameters bounded).
- Reset mid-operation: immediate IDLE, inst=0; partial data discarded.
- Total cycles with continuous in_valid: 1+total_cycle+col+(col+2)+2*gap_cycle+3*total_cycle+drain_cycle+total_cycle*(1+handshake_cycle)+1.

Test Plan:
- Defaults, in_valid always 1, start pulse -> qmem_wr with add 0..7, kmem_wr add 0..7, done pulse exactly 1+8+8+10+20+24+6+88+1=166 cycles after start; inst=0 afterward.
- QWR with in_valid toggling 1,0,1,0 -> inst=0 on bubbles, qkmem_add increments only on accepts, mem_in equals accepted in_data.
- LOAD window -> 10 cycles load=1; kmem_rd on cycles 1..8 with add 0..7; load=0 on cycle 10.
- DIV window -> pmem_add steps 0..7 each held 11 cycles, div=1 and pmem_rd=1 throughout.
- Assert reset during EXEC (cycle 3) -> inst=0, busy=0, phase=0 same cycle; new start reruns full sequence correctly.
- start pulsed while busy and during DONE -> ignored; exactly one done per accepted start; full dual-core fullchip run reproduces hand-driven bench results.
